// File: rtl/conv_pkg.sv
// Shared constants and helpers for the 5x5 convolution datapath.
package conv_pkg;

  localparam int K               = 5;
  localparam int KK              = K * K;
  localparam int LB_ROWS         = K - 1;
  localparam int PIXEL_WIDTH_DEF = 9;

  // Flat element index of window pixel p_rc; r=0 is the oldest row, c=0 the leftmost column.
  function automatic int win_idx(input int r, input int c);
    return r * K + c;
  endfunction

endpackage

// File: rtl/line_buffer_ram.sv
// Simple dual-port line memory holding all buffered rows of one column in a single word.
// Synchronous read; a write to the address being read is forwarded to the read port.
module line_buffer_ram #(
  parameter int DEPTH = 28,
  parameter int WIDTH = 36,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && (wr_addr == rd_addr)) begin
      rd_data <= wr_data;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/conv_window_gen_5x5.sv
// Streaming 5x5 sliding-window generator feeding conv_pe_5x5 (raster pixels in, 25-pixel windows out).
// Define WINGEN_ERR_EN to add the sticky frame_err output that flags framing faults.
module conv_window_gen_5x5
  import conv_pkg::*;
#(
  parameter int PIXEL_WIDTH = PIXEL_WIDTH_DEF,
  parameter int IMG_WIDTH   = 28,
  parameter int IMG_HEIGHT  = 28
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pix_valid,
  input  logic                          pix_sof,
  input  logic signed [PIXEL_WIDTH-1:0] pix_data,
  output logic                          win_valid,
  output logic [KK*PIXEL_WIDTH-1:0]     win_data,
  output logic                          win_last,
  output logic                          frame_done
`ifdef WINGEN_ERR_EN
  ,
  output logic                          frame_err
`endif
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int LW = LB_ROWS * PIXEL_WIDTH;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_WIN0 = CW'(K - 1);
  localparam logic [RW-1:0] ROW_WIN0 = RW'(K - 1);

  logic                      accept;
  logic [CW-1:0]             col, col_eff, col_next;
  logic [RW-1:0]             row, row_eff, row_next;
  logic                      last_pix;
  logic                      win_hit;
  logic [CW-1:0]             rd_addr;
  logic [LW-1:0]             lb_rd;
  logic [LW-1:0]             lb_wr;
  logic [KK*PIXEL_WIDTH-1:0] win_q;
  logic [KK*PIXEL_WIDTH-1:0] win_nx;

  assign accept = pix_valid && !rst;

  // A start-of-frame pixel is handled as though the counters already sat at (0,0).
  // The read address tracks the column of the next pixel so the synchronous RAM
  // output is ready by the time that pixel arrives.
  always_comb begin
    col_eff = col;
    row_eff = row;
    if (accept && pix_sof) begin
      col_eff = '0;
      row_eff = '0;
    end
    last_pix = (row_eff == ROW_LAST) && (col_eff == COL_LAST);
    win_hit  = accept && (row_eff >= ROW_WIN0) && (col_eff >= COL_WIN0);
    col_next = col;
    row_next = row;
    if (accept) begin
      if (col_eff == COL_LAST) begin
        col_next = '0;
        row_next = (row_eff == ROW_LAST) ? '0 : row_eff + RW'(1);
      end else begin
        col_next = col_eff + CW'(1);
        row_next = row_eff;
      end
    end
    rd_addr = rst ? '0 : col_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else begin
      col <= col_next;
      row <= row_next;
    end
  end

  // Column word ages by one row: oldest row drops out, the new pixel becomes the newest row.
  assign lb_wr = {pix_data, lb_rd[LW-1:PIXEL_WIDTH]};

  line_buffer_ram #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (LW),
    .AW    (CW)
  ) u_line_buffer (
    .clk     (clk),
    .wr_en   (accept),
    .wr_addr (col_eff),
    .wr_data (lb_wr),
    .rd_addr (rd_addr),
    .rd_data (lb_rd)
  );

  always_comb begin
    win_nx = win_q;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) begin
        win_nx[win_idx(r, c) * PIXEL_WIDTH +: PIXEL_WIDTH] =
          win_q[win_idx(r, c + 1) * PIXEL_WIDTH +: PIXEL_WIDTH];
      end
    end
    for (int r = 0; r < K - 1; r++) begin
      win_nx[win_idx(r, K - 1) * PIXEL_WIDTH +: PIXEL_WIDTH] = lb_rd[r * PIXEL_WIDTH +: PIXEL_WIDTH];
    end
    win_nx[win_idx(K - 1, K - 1) * PIXEL_WIDTH +: PIXEL_WIDTH] = pix_data;
  end

  // win_q slides on every pixel; win_data only captures complete windows so it holds between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_q      <= '0;
      win_data   <= '0;
      win_valid  <= 1'b0;
      win_last   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      win_valid  <= win_hit;
      win_last   <= win_hit && last_pix;
      frame_done <= accept && last_pix;
      if (accept) begin
        win_q <= win_nx;
      end
      if (win_hit) begin
        win_data <= win_nx;
      end
    end
  end

`ifdef WINGEN_ERR_EN
  logic frame_ended;

  // Flags a resync that lands mid-frame, or a new frame that starts without its SOF marker.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err   <= 1'b0;
      frame_ended <= 1'b0;
    end else if (accept) begin
      frame_ended <= last_pix;
      if ((pix_sof && ((row != '0) || (col != '0))) || (!pix_sof && frame_ended)) begin
        frame_err <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_conv_window_gen_5x5.sv
// Self-checking bench for conv_window_gen_5x5: an image-array reference model plus literal checks.
// Build with WINGEN_ERR_EN to also check the frame_err output.
module tb_conv_window_gen_5x5;

  localparam int PW = 9;
  localparam int W  = 28;
  localparam int H  = 28;
  localparam int NW = 25 * PW;

  logic          clk;
  logic          rst;
  logic          pix_valid;
  logic          pix_sof;
  logic [PW-1:0] pix_data;
  logic          win_valid;
  logic [NW-1:0] win_data;
  logic          win_last;
  logic          frame_done;
`ifdef WINGEN_ERR_EN
  logic          frame_err;
`endif

  conv_window_gen_5x5 #(
    .PIXEL_WIDTH (PW),
    .IMG_WIDTH   (W),
    .IMG_HEIGHT  (H)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_valid  (pix_valid),
    .pix_sof    (pix_sof),
    .pix_data   (pix_data),
    .win_valid  (win_valid),
    .win_data   (win_data),
    .win_last   (win_last),
    .frame_done (frame_done)
`ifdef WINGEN_ERR_EN
    ,
    .frame_err  (frame_err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec  = 0;
  int n_miss = 0;

  logic          started = 1'b0;
  logic [PW-1:0] img [H][W];
  int            mrow, mcol, acc_count;
  logic          m_ended;
  logic          exp_valid, exp_last, exp_done;
  logic [NW-1:0] exp_data;
`ifdef WINGEN_ERR_EN
  logic          exp_err;
`endif

  logic [NW-1:0] win_log [$];
  int            acc_log [$];
  logic          last_log [$];
  logic          done_log [$];
  int            log_base = 0;
  int            acc_base = 0;
  int            lit_req  = 0;
  int            lit_done = 0;

  function automatic logic [PW-1:0] elem(input logic [NW-1:0] w, input int r, input int c);
    return w[(r * 5 + c) * PW +: PW];
  endfunction

  task automatic checkOutput(input string name, input logic [NW-1:0] act, input logic [NW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: remembers the current frame as a 2-D image and cuts the 5x5 window out of it.
  initial begin
    forever begin
      @(posedge clk);
      started = 1'b1;
      if (rst) begin
        mrow = 0; mcol = 0; m_ended = 1'b0;
        exp_valid = 1'b0; exp_last = 1'b0; exp_done = 1'b0; exp_data = '0;
`ifdef WINGEN_ERR_EN
        exp_err = 1'b0;
`endif
      end else begin
        exp_valid = 1'b0; exp_last = 1'b0; exp_done = 1'b0;
        if (pix_valid) begin
          acc_count++;
          if (pix_sof) begin
`ifdef WINGEN_ERR_EN
            if (mrow != 0 || mcol != 0) exp_err = 1'b1;
`endif
            mrow = 0; mcol = 0;
          end else begin
`ifdef WINGEN_ERR_EN
            if (m_ended) exp_err = 1'b1;
`endif
          end
          img[mrow][mcol] = pix_data;
          exp_done = (mrow == H - 1) && (mcol == W - 1);
          if (mrow >= 4 && mcol >= 4) begin
            exp_valid = 1'b1;
            exp_last  = exp_done;
            for (int i = 0; i < 5; i++)
              for (int j = 0; j < 5; j++)
                exp_data[(i * 5 + j) * PW +: PW] = img[mrow - 4 + i][mcol - 4 + j];
          end
          m_ended = exp_done;
          mcol++;
          if (mcol == W) begin
            mcol = 0;
            mrow = (mrow == H - 1) ? 0 : mrow + 1;
          end
        end
      end
    end
  end

  task automatic checkLiterals(input int id);
    int cnt, fa;
    logic [NW-1:0] fw, lw;
    cnt = win_log.size() - log_base;
    fa  = (cnt > 0) ? acc_log[log_base] - acc_base : -1;
    fw  = (cnt > 0) ? win_log[log_base] : '0;
    lw  = (cnt > 0) ? win_log[win_log.size() - 1] : '0;
    case (id)
      10, 11: begin
        checkOutput("rst_win_valid", win_valid, '0);
        checkOutput("rst_win_data", win_data, '0);
        checkOutput("rst_win_last", win_last, '0);
        checkOutput("rst_frame_done", frame_done, '0);
`ifdef WINGEN_ERR_EN
        checkOutput("rst_frame_err", frame_err, '0);
`endif
      end
      1, 2, 4, 5: begin
        checkOutput($sformatf("t%0d_count", id), cnt, 576);
        checkOutput($sformatf("t%0d_first_at_pixel", id), fa, 117);
        if (cnt > 0) begin
          checkOutput($sformatf("t%0d_first_p00", id), elem(fw, 0, 0), 0);
          checkOutput($sformatf("t%0d_first_p44", id), elem(fw, 4, 4), 116);
          checkOutput($sformatf("t%0d_last_p44", id), elem(lw, 4, 4), 15);
          checkOutput($sformatf("t%0d_last_flag", id), last_log[last_log.size() - 1], 1);
          checkOutput($sformatf("t%0d_last_done", id), done_log[done_log.size() - 1], 1);
        end
`ifdef WINGEN_ERR_EN
        if (id == 5) checkOutput("t5_frame_err", frame_err, 1);
`endif
      end
      3: begin
        checkOutput("t3_count", cnt, 1152);
        if (cnt >= 1152) begin
          checkOutput("t3_f1_p00", elem(fw, 0, 0), 50);
          checkOutput("t3_f1_last_flag", last_log[log_base + 575], 1);
          checkOutput("t3_f2_p00", elem(win_log[log_base + 576], 0, 0), 0);
          checkOutput("t3_f2_p44", elem(win_log[log_base + 576], 4, 4), 116);
        end
      end
      6: begin
        checkOutput("t6_count", cnt, 576);
        if (cnt > 0) begin
          checkOutput("t6_p00_neg", elem(fw, 0, 0), 9'h100);
          checkOutput("t6_p01_pos", elem(fw, 0, 1), 9'h0FF);
          checkOutput("t6_last_p44", elem(lw, 4, 4), 9'h100);
        end
      end
      7: begin
`ifdef WINGEN_ERR_EN
        checkOutput("t7_frame_err_sticky", frame_err, 1);
`endif
      end
      default: ;
    endcase
  endtask

  // Single compare process: every cycle against the model, plus literal checks on request.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        checkOutput("win_valid", win_valid, exp_valid);
        checkOutput("win_last", win_last, exp_last);
        checkOutput("frame_done", frame_done, exp_done);
        checkOutput("win_data", win_data, exp_data);
`ifdef WINGEN_ERR_EN
        checkOutput("frame_err", frame_err, exp_err);
`endif
        if (win_valid === 1'b1) begin
          win_log.push_back(win_data);
          acc_log.push_back(acc_count);
          last_log.push_back(win_last);
          done_log.push_back(frame_done);
        end
      end
      if (lit_req != lit_done) begin
        checkLiterals(lit_req);
        lit_done = lit_req;
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic s, input logic [PW-1:0] d);
    @(negedge clk);
    pix_valid = v;
    pix_sof   = s;
    pix_data  = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0);
  endtask

  task automatic clearLog();
    @(posedge clk);
    #1;
    log_base = win_log.size();
    acc_base = acc_count;
  endtask

  task automatic requestLiterals(input int id);
    lit_req = id;
    for (int k = 0; k < 10 && lit_done != id; k++) @(negedge clk);
    if (lit_done != id) begin
      $display("[TB] FAIL literal_request_%0d: got no service, expected service within 10 cycles", id);
      $fatal(1, "[TB] compare process stalled");
    end
  endtask

  // Raster frame; gap cycles may carry a stray SOF without valid, which must be ignored.
  task automatic sendFrame(input int npix, input int offset, input bit gaps, input bit with_sof, input bit extreme);
    logic [PW-1:0] d;
    for (int i = 0; i < npix; i++) begin
      if (gaps && $urandom_range(1, 0) == 1)
        applyStimulus(1'b0, 1'($urandom_range(1, 0)), PW'($urandom_range(511, 0)));
      if (extreme) d = (((i / W) + (i % W)) % 2 == 1) ? 9'h0FF : 9'h100;
      else         d = PW'((i + offset) & 255);
      applyStimulus(1'b1, with_sof && (i == 0), d);
    end
  endtask

  initial begin
    rst = 1'b1; pix_valid = 1'b0; pix_sof = 1'b0; pix_data = '0;
    acc_count = 0;
    repeat (3) @(negedge clk);
    requestLiterals(10);
    rst = 1'b0;

    clearLog(); sendFrame(784, 0, 1'b0, 1'b1, 1'b0); idle(4); requestLiterals(1);
    clearLog(); sendFrame(784, 0, 1'b1, 1'b1, 1'b0); idle(4); requestLiterals(2);
    clearLog(); sendFrame(784, 50, 1'b0, 1'b1, 1'b0); sendFrame(784, 0, 1'b0, 1'b1, 1'b0);
    idle(4); requestLiterals(3);

    sendFrame(301, 0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    requestLiterals(11);
    rst = 1'b0; pix_valid = 1'b0;
    idle(2);
    clearLog(); sendFrame(784, 0, 1'b0, 1'b0, 1'b0); idle(4); requestLiterals(4);

    clearLog(); sendFrame(200, 0, 1'b0, 1'b1, 1'b0);
    clearLog(); sendFrame(784, 0, 1'b0, 1'b1, 1'b0); idle(4); requestLiterals(5);
    idle(20); requestLiterals(7);

    @(negedge clk);
    rst = 1'b1; pix_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clearLog(); sendFrame(784, 0, 1'b0, 1'b1, 1'b1); idle(4); requestLiterals(6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/conv_window_gen_5x5.md
# conv_window_gen_5x5

- Streaming 5x5 sliding-window generator.
- Accepts a raster-order pixel stream (one pixel per valid cycle) and buffers the last four image rows in line buffers.
- Emits a complete 25-pixel window every time a valid (stride-1, no padding) 5x5 position completes.
- Sits directly in front of `conv_pe_5x5` and drives its `valid_in` and its `p00..p44` inputs.

## Interface

Parameters:
- `PIXEL_WIDTH`, 9, signed pixel width; matches the PE pixel width.
- `IMG_WIDTH`, 28, pixels per row; must be ≥ 5.
- `IMG_HEIGHT`, 28, rows per frame; must be ≥ 5.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pix_valid`  in  1  pixel strobe; `pix_data` is accepted on every cycle this is high.
- `pix_sof`  in  1  start of frame; only meaningful when `pix_valid` is high.
- `pix_data`  in  `PIXEL_WIDTH`  signed pixel value.
- `win_valid`  out  1  one-cycle pulse; `win_data` holds a new window.
- `win_data`  out  `25*PIXEL_WIDTH`  window; element `p_rc` sits at `[(r*5+c)*PIXEL_WIDTH +: PIXEL_WIDTH]`.
  - `r=0` is the oldest row; `c=0` is the leftmost column.
  - `p44` is the newest pixel.
- `win_last`  out  1  high together with `win_valid` for the final window of the frame.
- `frame_done`  out  1  one-cycle pulse after the pixel at (`IMG_HEIGHT-1`, `IMG_WIDTH-1`) is accepted.
- `frame_err`  out  1  sticky error flag; present only with `WINGEN_ERR_EN`.

## Operation

- Counters: `col` runs 0..`IMG_WIDTH-1` and `row` runs 0..`IMG_HEIGHT-1`. Both advance only on accepted pixels.
  - `col` wraps to 0 and increments `row`.
  - At (`IMG_HEIGHT-1`, `IMG_WIDTH-1`), both wrap to 0 and `frame_done` pulses.
- Line buffers: 4 rows × `IMG_WIDTH` entries.
  - On each accepted pixel, the column entry at `col` shifts upward (row k ← row k+1) and the newest row ← `pix_data`.
  - This is a read-before-write at the same address within one cycle.
- Window register: 5×5 array. On an accepted pixel, every row shifts left by one column. The new column 4 is loaded as:
  - rows 0..3 from the line-buffer read at `col`;
  - row 4 from `pix_data`.
- A window is valid when the accepted pixel has `row ≥ 4` and `col ≥ 4`. This gives `(IMG_HEIGHT-4)*(IMG_WIDTH-4)` windows per frame, 576 at the defaults.
- `win_last` is asserted for the window completed by pixel (`IMG_HEIGHT-1`, `IMG_WIDTH-1`).
- `pix_sof` with `pix_valid`: that pixel is treated as (0,0) and the counters restart from it. Line-buffer contents are not cleared; stale data never reaches a valid window.
- `pix_sof` without `pix_valid` is ignored.
- Pixel data passes through unchanged; no arithmetic, no sign change.

## Timing

- Reset values: `win_valid=0`, `win_last=0`, `frame_done=0`, `win_data=0`, `frame_err=0`, `row=col=0`.
- Line-buffer RAM contents are not reset.
- Reset mid-frame: the next accepted pixel is (0,0) and no window appears until row 4, col 4 of the new stream.
- Latency: `win_valid`, `win_data` and `win_last` are registered and appear 1 cycle after the completing pixel is accepted.
- `frame_done` appears on the same cycle as the final `win_valid`.
- Throughput: one pixel per cycle; gaps in `pix_valid` are allowed and do not corrupt state.
- No backpressure. The downstream PE accepts one window per cycle unconditionally.
- `win_data` holds its value between pulses.
- `rst` has priority over `pix_valid` in the same cycle.

## Configuration

- `WINGEN_ERR_EN` defined:
  - `frame_err` is set on the cycle after `pix_sof && pix_valid` is seen while (`row`, `col`) ≠ (0,0).
  - It also sets after a frame ends and a new pixel arrives without `pix_sof`.
  - It stays set until `rst`.
- `WINGEN_ERR_EN` undefined: the `frame_err` port and its logic are absent, and resync via `pix_sof` still works.

## Structure

- Shared package `conv_pkg`:
  - kernel size `K=5`, window count `KK=25`;
  - default `PIXEL_WIDTH`;
  - a packing helper for the window-element index `(r*K+c)`.
- Sub-module `line_buffer_ram`:
  - simple dual-port, depth `IMG_WIDTH`, width `4*PIXEL_WIDTH`;
  - synchronous read with write-first bypass at the same address.
  - It holds all 4 rows in one word, so one read and one write happen per pixel.

## Test plan

- 28×28 frame, `pix_data=(row*28+col)&8'hFF`, continuous valid:
  - exactly 576 `win_valid` pulses;
  - the first comes 1 cycle after pixel 116, with `p00=0` and `p44=116`;
  - the last has `win_last=1`, `p44=(783&255)=15`, and `frame_done` in the same cycle.
- Same frame with 50% random `pix_valid` gaps → identical 576-window sequence and contents.
- Two back-to-back frames → the second frame's first window is `p00=0` with no rows from frame 1; 1152 windows total.
- `rst` asserted after pixel 300, then a fresh frame → no `win_valid` until its 117th pixel, and all outputs are 0 during reset.
- `pix_sof` on pixel 200 of a frame → counters restart and the first window follows 117 pixels later; `frame_err=1` and sticky with `WINGEN_ERR_EN`.
- Pixels of -256 and 255 → passed bit-exact into `win_data`.
